// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
// March C- memory BIST engine that sits directly in front of the memory under test.
// It issues one memory operation per cycle in this order:
//   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0).
// Returned read data is checked, and the first failure is reported to the test host.
//
// Ports:
//   clk           - single clock; all state changes on the rising edge
//   rst_n         - asynchronous, active-low reset
//   start         - one-cycle pulse; starts a run when the engine is idle or done
//   write_read    - memory command: 1 = write, 0 = read
//   address       - memory address (never exceeds CAPACITY)
//   wdata         - write data, presented one cycle ahead of its write
//   rdata         - memory read data, valid two cycles after the read is issued
//   busy          - high while operations are issued or reads are still in flight
//   done          - level; run finished, held until the next accepted start
//   fail          - sticky mismatch flag for the current or last run
//   fail_addr     - address of the first mismatch
//   fail_elem     - March element (0..5) of the first mismatch
//   fail_syndrome - rdata XOR expected data at the first mismatch
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syndrome
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One March operation: element, address, and phase (0 = read half, 1 = write half).
  typedef struct packed {
    logic                  valid;
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  phase;
  } op_t;

  // A read in flight: data it should return, plus where it came from.
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] expect_data;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
  } cmp_t;

  state_t state;
  op_t    cur_op, op_next, op_next2, first_op, first_next;
  cmp_t   pipe_in, pipe0, pipe1;
  logic   drain_cnt;

  function automatic logic two_op(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic is_write(input logic [2:0] e, input logic ph);
    if (e == 3'd0) return 1'b1;
    if (e == 3'd5) return 1'b0;
    return ph;
  endfunction

  // Write data for write ops, or the data a read is expected to return.
  function automatic logic [DATA_WIDTH-1:0] op_data(input logic [2:0] e, input logic ph);
    logic ones;
    if (is_write(e, ph)) ones = (e == 3'd1) || (e == 3'd3);
    else                 ones = (e == 3'd2) || (e == 3'd4);
    return ones ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  endfunction

  // Data to place on wdata ahead of an op; zero unless that op is a real write.
  function automatic logic [DATA_WIDTH-1:0] ahead_data(input op_t o);
    if (o.valid && is_write(o.elem, o.phase)) return op_data(o.elem, o.phase);
    return '0;
  endfunction

  // Successor of an op.
  // A two-op element does its write at the same address before the address steps.
  // The last address of an element rolls straight into the next element with no gap.
  function automatic op_t next_op(input op_t o);
    op_t n;
    n = o;
    if (!o.valid) begin
      n.valid = 1'b0;
    end else if (two_op(o.elem) && !o.phase) begin
      n.phase = 1'b1;
    end else begin
      n.phase = 1'b0;
      if (is_down(o.elem) ? (o.addr == '0) : (o.addr == LAST_ADDR)) begin
        if (o.elem == 3'd5) begin
          n.valid = 1'b0;
        end else begin
          n.elem = o.elem + 3'd1;
          n.addr = is_down(o.elem + 3'd1) ? LAST_ADDR : '0;
        end
      end else begin
        n.addr = is_down(o.elem) ? o.addr - 1'b1 : o.addr + 1'b1;
      end
    end
    return n;
  endfunction

  // Lookahead: the op to issue next, and the op after it, whose data wdata must present early.
  always_comb begin
    first_op       = '0;
    first_op.valid = 1'b1;
    first_next     = next_op(first_op);
    op_next        = next_op(cur_op);
    op_next2       = next_op(op_next);

    pipe_in             = '0;
    pipe_in.valid       = (state == RUN) && !write_read;
    pipe_in.expect_data = op_data(cur_op.elem, cur_op.phase);
    pipe_in.addr        = address;
    pipe_in.elem        = cur_op.elem;
  end

  // Main sequencer.
  // The two-stage compare pipeline shifts every cycle, so a read issued in cycle k is
  // checked against rdata at the end of cycle k+2.
  // A start that is accepted clears the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_op        <= '0;
      drain_cnt     <= 1'b0;
      pipe0         <= '0;
      pipe1         <= '0;
      write_read    <= 1'b0;
      address       <= '0;
      wdata         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_syndrome <= '0;
    end else begin
      pipe0 <= pipe_in;
      pipe1 <= pipe0;
      if (pipe1.valid && (rdata != pipe1.expect_data)) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr     <= pipe1.addr;
          fail_elem     <= pipe1.elem;
          fail_syndrome <= rdata ^ pipe1.expect_data;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_syndrome <= '0;
            cur_op        <= first_op;
            write_read    <= 1'b1;
            address       <= '0;
            wdata         <= ahead_data(first_next);
          end
        end
        RUN: begin
          if (op_next.valid) begin
            cur_op     <= op_next;
            write_read <= is_write(op_next.elem, op_next.phase);
            address    <= op_next.addr;
            wdata      <= ahead_data(op_next2);
          end else begin
            state      <= DRAIN;
            drain_cnt  <= 1'b0;
            cur_op     <= '0;
            write_read <= 1'b0;
            address    <= '0;
            wdata      <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl
// Bench for the March C- BIST engine.
// A small memory with an optional stuck-at-1 fault is built here, using two-cycle read latency.
// The expected operation list and the first failure come from a plain description of March C-.
module tb_mbist_march_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int CAP   = 15;
  localparam int N     = CAP + 1;
  localparam int TOTAL = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_syndrome;

  int compared   = 0;
  int mismatched = 0;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_syndrome(fail_syndrome)
  );

  always #5 clk = ~clk;

  // Memory under test.
  // Write data is registered one edge before the write edge, and reads return data two cycles later.
  // An OR mask applied at faultAddr models a stuck-at-1 cell on the read path.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wreg, r1;
  logic [AW-1:0] faultAddr;
  logic [DW-1:0] faultMask;

  always @(posedge clk) begin
    wreg <= wdata;
    if (write_read) mem[address] <= wreg;
    r1    <= mem[address] | ((address == faultAddr) ? faultMask : '0);
    rdata <= r1;
  end

  // Expected operation list, built straight from the March C- notation.
  logic          opWe   [TOTAL];
  logic [AW-1:0] opAddr [TOTAL];
  logic [2:0]    opElem [TOTAL];
  logic [DW-1:0] opData [TOTAL];

  task automatic pushOp(inout int k, input logic we, input int a, input int e, input logic ones);
    opWe[k]   = we;
    opAddr[k] = AW'(a);
    opElem[k] = 3'(e);
    opData[k] = ones ? '1 : '0;
    k++;
  endtask

  task automatic buildOps();
    int k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < N; s++) begin
        int a = (e == 3 || e == 4) ? (N - 1 - s) : s;
        if (e == 0)      pushOp(k, 1'b1, a, e, 1'b0);
        else if (e == 5) pushOp(k, 1'b0, a, e, 1'b0);
        else begin
          pushOp(k, 1'b0, a, e, (e == 2 || e == 4));
          pushOp(k, 1'b1, a, e, (e == 1 || e == 3));
        end
      end
    end
  endtask

  // First failure the run must report, given the fault currently set.
  int            misIdx;
  logic [AW-1:0] misAddr;
  logic [2:0]    misElem;
  logic [DW-1:0] misSyn;

  task automatic computeMismatch();
    logic [DW-1:0] img [N];
    logic [DW-1:0] got;
    misIdx = -1; misAddr = '0; misElem = '0; misSyn = '0;
    for (int k = 0; k < TOTAL; k++) begin
      if (opWe[k]) img[opAddr[k]] = opData[k];
      else begin
        got = img[opAddr[k]] | ((opAddr[k] == faultAddr) ? faultMask : '0);
        if (got != opData[k] && misIdx < 0) begin
          misIdx = k; misAddr = opAddr[k]; misElem = opElem[k]; misSyn = got ^ opData[k];
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model timeline.
  // runCyc is the cycle number within the current run: 1 is the first cycle after the
  // accepting edge, and 0 means no run since reset.
  int runCyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runCyc = 0;
      misIdx = -1;
    end else if (start && !(runCyc >= 1 && runCyc <= TOTAL + 2)) begin
      runCyc = 1;
      computeMismatch();
    end else if (runCyc >= 1 && runCyc < 100000) begin
      runCyc++;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  logic [DW-1:0] prevW = '0;

  always @(negedge clk) begin
    int  c;
    logic expFail;
    c = runCyc;
    if (rst_n) begin
      checkOutput("busy", busy, (c >= 1 && c <= TOTAL + 2));
      checkOutput("done", done, (c >= TOTAL + 3));
      if (c >= 1 && c <= TOTAL) begin
        checkOutput("op_we", write_read, opWe[c-1]);
        checkOutput("op_addr", address, opAddr[c-1]);
        if (opWe[c-1]) checkOutput("op_wdata", prevW, opData[c-1]);
      end else begin
        checkOutput("idle_we", write_read, 0);
        checkOutput("idle_addr", address, 0);
        checkOutput("idle_wdata", wdata, 0);
      end
      expFail = (c >= 1) && (misIdx >= 0) && (c >= misIdx + 4);
      checkOutput("fail", fail, expFail);
      checkOutput("fail_addr", fail_addr, expFail ? misAddr : '0);
      checkOutput("fail_elem", fail_elem, expFail ? misElem : '0);
      checkOutput("fail_syndrome", fail_syndrome, expFail ? misSyn : '0);
    end
    prevW = wdata;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Start a run, optionally pulse start again or assert reset at a given cycle, and
  // report the cycle in which done was first seen (-1 if not seen).
  task automatic applyStimulus(input int pulseAt, input int resetAt, output int doneCyc);
    int n;
    doneCyc = -1;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    n = 1;
    while (n < 400) begin
      if (done) begin
        doneCyc = n;
        break;
      end
      if (n == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_we", write_read, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_addr", address, 0);
        checkOutput("rst_wdata", wdata, 0);
        tick(); rst_n = 1'b1;
        tick();
        return;
      end
      start = (n == pulseAt);
      tick();
      n++;
    end
    start = 1'b0;
    if (doneCyc < 0) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; faultAddr = 4'd5; faultMask = '0;
    buildOps();
    #12;
    checkOutput("reset_we", write_read, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_fail", fail, 0);
    checkOutput("reset_wdata", wdata, 0);
    tick(); rst_n = 1'b1;
    tick();

    // Clean run
    applyStimulus(-1, -1, dc);
    checkOutput("clean_done_cycle", dc, 163);
    checkOutput("clean_fail", fail, 0);
    checkOutput("clean_syndrome", fail_syndrome, 0);

    // start pulsed while busy must be ignored
    applyStimulus(50, -1, dc);
    checkOutput("busy_start_done_cycle", dc, 163);

    // Stuck-at-1 on bit 3 of address 5
    faultMask = 8'h08;
    applyStimulus(-1, -1, dc);
    checkOutput("fault_done_cycle", dc, 163);
    checkOutput("fault_fail", fail, 1);
    checkOutput("fault_addr", fail_addr, 5);
    checkOutput("fault_elem", fail_elem, 1);
    checkOutput("fault_syndrome", fail_syndrome, 8'h08);
    checkOutput("model_mis_idx", misIdx, 26);

    // Rerun with the fault removed: result cleared on accept
    faultMask = '0;
    applyStimulus(-1, -1, dc);
    checkOutput("rerun_done_cycle", dc, 163);
    checkOutput("rerun_fail", fail, 0);

    // Reset mid-run, then a full clean pass
    applyStimulus(-1, 80, dc);
    applyStimulus(-1, -1, dc);
    checkOutput("post_reset_done_cycle", dc, 163);
    checkOutput("post_reset_fail", fail, 0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
